// File: rtl/lector_adc_mcp3201_pkg.sv
// adc_pkg: shared constants and FSM state codes for the MCP3201 serial reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: MCP3201 frame geometry (clk_adc pulses per frame, data bits,
// rise number that carries the null bit) and the reader state encoding.
package adc_pkg;

  // MCP3201 frame geometry: 15 clocks per read, 12 data bits, null bit on rise 3.
  localparam int MCP_TOTAL_BITS = 15;
  localparam int MCP_DATOS_BITS = 12;
  localparam int MCP_IDX_NULO   = 3;

  // Reader FSM encoding, kept as plain constants so older tools can consume it.
  typedef logic [2:0] estado_t;

  localparam estado_t REPOSO    = 3'd0;
  localparam estado_t ACTIVA_CS = 3'd1;
  localparam estado_t RELOJ     = 3'd2;
  localparam estado_t FIN       = 3'd3;
  localparam estado_t ESPERA    = 3'd4;

endpackage

// File: rtl/lector_adc_mcp3201_generador_tick.sv
// generador_tick: half-period tick for the ADC serial clock.
// Latency: first tick DIV cycles after a clear, then one tick every DIV cycles.
// Backpressure: none; free-running apart from the synchronous clear.
//
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   i_limpia    synchronous clear; the counter restarts from 0 next cycle
//   o_tick      one-cycle pulse every DIV cycles (always high when DIV=1)
module generador_tick #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_limpia,
  output logic o_tick
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] ULTIMO = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_limpia || (r_cnt == ULTIMO)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == ULTIMO);

endmodule

// File: rtl/lector_adc_mcp3201.sv
// lector_adc_mcp3201: MCP3201 serial-read master, emits one 12-bit word per frame.
// Latency: strobe 2*DIV*total_bits cycles after cs falls (cs falls 1 cycle after inicio).
// Backpressure: none; the consumer must take dato on the dato_valido strobe.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   inicio            start request (only honoured while idle)
//   continuo          chain another frame after the cs-high gap
//   datos_adc         serial data from the ADC
//   clk_adc, cs       ADC serial clock (idles low) and chip select (active low)
//   dato, dato_valido converted word and its one-cycle strobe
//   err_nulo          null bit read as 1, qualified by dato_valido
//   ocupado           frame in progress (including the cs-high gap)
module lector_adc_mcp3201
  import adc_pkg::*;
#(
  parameter int DIV        = 4,
  parameter int datos_bits = MCP_DATOS_BITS,
  parameter int total_bits = MCP_TOTAL_BITS,
  parameter int T_CSH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inicio,
  input  logic                  continuo,
  input  logic                  datos_adc,
  output logic                  clk_adc,
  output logic                  cs,
  output logic [datos_bits-1:0] dato,
  output logic                  dato_valido,
  output logic                  err_nulo,
  output logic                  ocupado
);

  localparam int RW = $clog2(total_bits + 1);
  localparam int EW = $clog2(T_CSH + 1);
  localparam logic [RW-1:0] SUBIDAS_FIN = RW'(total_bits);
  localparam logic [EW-1:0] ESPERA_ULT  = EW'(T_CSH - 1);

  estado_t               r_estado;
  estado_t               w_estado_sig;
  logic [RW-1:0]         r_subidas;
  logic [EW-1:0]         r_espera;
  // Only the null bit and the data bits are ever read back; the undefined and
  // sample-phase bits fall off the top of the register before FIN.
  logic [datos_bits:0]   r_shift;
  logic                  r_clk_adc;
  logic                  r_cs;
  logic [datos_bits-1:0] r_dato;
  logic                  r_valido;
  logic                  r_err;
  logic                  r_ocupado;
  logic                  w_tick;
  logic                  w_entra_activa;
  logic                  w_reloj_activo;

  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      REPOSO:    if (inicio) w_estado_sig = ACTIVA_CS;
      ACTIVA_CS: if (w_tick) w_estado_sig = RELOJ;
      // Leave on the half-period boundary that would be the last falling edge.
      RELOJ:     if (w_tick && r_clk_adc && (r_subidas == SUBIDAS_FIN)) w_estado_sig = FIN;
      FIN:       w_estado_sig = ESPERA;
      ESPERA:    if (r_espera == ESPERA_ULT) w_estado_sig = continuo ? ACTIVA_CS : REPOSO;
      default:   w_estado_sig = REPOSO;
    endcase
  end

  assign w_entra_activa = (w_estado_sig == ACTIVA_CS) && (r_estado != ACTIVA_CS);
  // The ACTIVA_CS->RELOJ tick is itself the first rising edge of clk_adc.
  assign w_reloj_activo = (r_estado == ACTIVA_CS) || (r_estado == RELOJ);

  generador_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_limpia(w_entra_activa),
    .o_tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= REPOSO;
      r_cs      <= 1'b1;
      r_clk_adc <= 1'b0;
      r_dato    <= '0;
      r_valido  <= 1'b0;
      r_err     <= 1'b0;
      r_ocupado <= 1'b0;
      r_subidas <= '0;
      r_espera  <= '0;
      r_shift   <= '0;
    end else begin
      r_estado <= w_estado_sig;
      r_valido <= 1'b0;
      r_err    <= 1'b0;
      if (w_entra_activa) begin
        r_cs      <= 1'b0;
        r_ocupado <= 1'b1;
        r_clk_adc <= 1'b0;
        r_subidas <= '0;
      end else if (w_estado_sig == FIN) begin
        r_cs      <= 1'b1;
        r_clk_adc <= 1'b0;
        r_dato    <= r_shift[datos_bits-1:0];
        r_err     <= r_shift[datos_bits];
        r_valido  <= 1'b1;
        r_espera  <= '0;
      end else if (w_reloj_activo && w_tick) begin
        r_clk_adc <= ~r_clk_adc;
        if (!r_clk_adc) begin
          r_shift   <= {r_shift[datos_bits-1:0], datos_adc};
          r_subidas <= r_subidas + RW'(1);
        end
      end
      if (r_estado == ESPERA) begin
        r_espera <= r_espera + EW'(1);
        if (w_estado_sig == REPOSO) r_ocupado <= 1'b0;
      end
    end
  end

  assign clk_adc     = r_clk_adc;
  assign cs          = r_cs;
  assign dato        = r_dato;
  assign dato_valido = r_valido;
  assign err_nulo    = r_err;
  assign ocupado     = r_ocupado;

endmodule

// File: tb/tb_lector_adc_mcp3201.sv
// tb_lector_adc_mcp3201: self-checking bench for the MCP3201 reader.
// Latency: n/a.
// Backpressure: n/a.
module tb_lector_adc_mcp3201;

  localparam int DIV      = 4;
  localparam int T_CSH    = 8;
  localparam int TOT      = 15;
  localparam int T_FRAME  = 2 * DIV * TOT;
  localparam int T_FRAME1 = 2 * 1 * TOT;
  localparam int NV       = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n     = 1'b0;
  logic        inicio    = 1'b0;
  logic        continuo  = 1'b0;
  logic        datos_adc = 1'b0;
  logic        inicio1   = 1'b0;
  logic        clk_adc, cs, dato_valido, err_nulo, ocupado;
  logic [11:0] dato;
  logic        clk_adc1, cs1, dv1, err1, ocup1;
  logic [11:0] dato1;

  lector_adc_mcp3201 #(.DIV(DIV), .datos_bits(12), .total_bits(TOT), .T_CSH(T_CSH)) u_dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .continuo(continuo), .datos_adc(datos_adc),
    .clk_adc(clk_adc), .cs(cs), .dato(dato), .dato_valido(dato_valido),
    .err_nulo(err_nulo), .ocupado(ocupado)
  );

  lector_adc_mcp3201 #(.DIV(1), .datos_bits(12), .total_bits(TOT), .T_CSH(T_CSH)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .inicio(inicio1), .continuo(1'b0), .datos_adc(1'b1),
    .clk_adc(clk_adc1), .cs(cs1), .dato(dato1), .dato_valido(dv1),
    .err_nulo(err1), .ocupado(ocup1)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model and frame monitor, all observed half a cycle after the active edge.
  logic [14:0] frame_word = '0;
  int idx = 0, rises = 0, strobes = 0;
  int t_fall = 0, t_rise = 0, cs_low_len = 0, cs_high_len = 0;
  int t_strobe = 0, strobe_delta = 0, rises_at_strobe = 0, t_ocup_fall = 0;
  logic [11:0] last_dato = '0;
  logic        last_err = 1'b0;
  logic p_cs = 1'b1, p_ck = 1'b0, p_oc = 1'b0, p_cs1 = 1'b1;
  int t_fall1 = 0, strobes1 = 0, delta1 = 0;
  logic [11:0] ld1 = '0;
  logic        le1 = 1'b0;

  always @(negedge clk) begin
    if (p_cs && !cs) begin
      t_fall = cyc; cs_high_len = cyc - t_rise; idx = 0; rises = 0;
    end
    if (!p_cs && cs) begin
      t_rise = cyc; cs_low_len = cyc - t_fall;
    end
    if (!p_ck && clk_adc) rises++;
    if (p_ck && !clk_adc) idx++;
    if (dato_valido) begin
      strobes++; t_strobe = cyc; strobe_delta = cyc - t_fall;
      rises_at_strobe = rises; last_dato = dato; last_err = err_nulo;
    end
    if (p_oc && !ocupado) t_ocup_fall = cyc;
    p_cs = cs; p_ck = clk_adc; p_oc = ocupado;
    // The ADC presents bit (14-idx) of its frame; it advances after each clk_adc fall.
    datos_adc = (idx <= 14) ? frame_word[14 - idx] : 1'b0;
    if (p_cs1 && !cs1) t_fall1 = cyc;
    if (dv1) begin
      strobes1++; delta1 = cyc - t_fall1; ld1 = dato1; le1 = err1;
    end
    p_cs1 = cs1;
  end

  // Reference model: data word is the frame value mod 4096, null flag is bit 12.
  function automatic logic [11:0] m_dato(input logic [14:0] w);
    return 12'(int'(w) % 4096);
  endfunction
  function automatic logic m_err(input logic [14:0] w);
    return 1'((int'(w) / 4096) % 2);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse_inicio();
    inicio = 1'b1;
    tick(1);
    inicio = 1'b0;
  endtask

  task automatic wait_strobe(input int target, input string nm);
    int n = 0;
    while (strobes < target && n < 500) begin
      tick(1);
      n++;
    end
    chk(nm, 32'(strobes >= target), 32'd1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (ocupado && n < 100) begin
      tick(1);
      n++;
    end
    chk(nm, 32'(ocupado), 32'd0);
  endtask

  task automatic wait_rises(input int k, input string nm);
    int n = 0;
    while (rises < k && n < 300) begin
      tick(1);
      n++;
    end
    chk(nm, 32'(rises), 32'(k));
  endtask

  typedef struct {
    logic [14:0] word;
    logic [11:0] exp_dato;
    logic        exp_err;
  } vec_t;

  vec_t vecs[NV];

  initial begin : main
    int s0, ts1, ts2, ts3;
    logic [14:0] w;

    vecs[0] = '{15'b000_1110_0110_0011, 12'hE63, 1'b0};
    vecs[1] = '{15'b001_1110_0110_0011, 12'hE63, 1'b1};
    vecs[2] = '{15'h7FFF, 12'hFFF, 1'b1};
    vecs[3] = '{15'h0000, 12'h000, 1'b0};
    vecs[4] = '{15'b110_0000_0000_0000, 12'h000, 1'b0};
    vecs[5] = '{15'b000_1000_0000_0001, 12'h801, 1'b0};
    for (int i = 6; i < NV; i++) begin
      w = 15'($urandom_range(0, 32767));
      vecs[i] = '{w, m_dato(w), m_err(w)};
    end

    tick(3);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_clk_adc", 32'(clk_adc), 32'd0);
    chk("rst_dato", 32'(dato), 32'd0);
    chk("rst_valido", 32'(dato_valido), 32'd0);
    chk("rst_err", 32'(err_nulo), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    rst_n = 1'b1;
    tick(3);

    for (int i = 0; i < NV; i++) begin
      frame_word = vecs[i].word;
      s0 = strobes;
      pulse_inicio();
      chk("cs_fall", 32'(cs), 32'd0);
      chk("ocupado_rise", 32'(ocupado), 32'd1);
      wait_strobe(s0 + 1, "strobe_arrived");
      chk("dato", 32'(last_dato), 32'(vecs[i].exp_dato));
      chk("err_nulo", 32'(last_err), 32'(vecs[i].exp_err));
      chk("fin_latency", strobe_delta, T_FRAME);
      chk("rise_count", rises_at_strobe, TOT);
      chk("cs_low_len", cs_low_len, T_FRAME);
      wait_idle("ocupado_fell");
      chk("ocupado_fall_time", t_ocup_fall - t_strobe, T_CSH + 1);
      chk("dato_hold", 32'(dato), 32'(vecs[i].exp_dato));
      chk("err_cleared", 32'(err_nulo), 32'd0);
      tick(2);
    end

    // Back-to-back frames in continuous mode.
    w = 15'($urandom_range(0, 32767));
    frame_word = w;
    continuo = 1'b1;
    s0 = strobes;
    pulse_inicio();
    wait_strobe(s0 + 1, "cont_strobe1");
    ts1 = t_strobe;
    chk("cont_dato1", 32'(last_dato), 32'(m_dato(w)));
    wait_strobe(s0 + 2, "cont_strobe2");
    ts2 = t_strobe;
    chk("cont_fin_to_fin1", ts2 - ts1, T_FRAME + T_CSH + 1);
    chk("cont_cs_high1", cs_high_len, T_CSH + 1);
    chk("cont_ocupado", 32'(ocupado), 32'd1);
    chk("cont_dato2", 32'(last_dato), 32'(m_dato(w)));
    wait_strobe(s0 + 3, "cont_strobe3");
    continuo = 1'b0;
    ts3 = t_strobe;
    chk("cont_fin_to_fin2", ts3 - ts2, T_FRAME + T_CSH + 1);
    chk("cont_cs_high2", cs_high_len, T_CSH + 1);
    chk("cont_err3", 32'(last_err), 32'(m_err(w)));
    tick(300);
    chk("cont_stops", strobes, s0 + 3);
    chk("cont_idle", 32'(ocupado), 32'd0);

    // inicio during RELOJ and during ESPERA is ignored.
    frame_word = vecs[0].word;
    s0 = strobes;
    pulse_inicio();
    wait_rises(5, "ign_reach_rise5");
    pulse_inicio();
    wait_strobe(s0 + 1, "ign_strobe");
    chk("ign_latency", strobe_delta, T_FRAME);
    tick(3);
    pulse_inicio();
    tick(300);
    chk("ign_strobe_count", strobes, s0 + 1);
    chk("ign_idle", 32'(ocupado), 32'd0);

    // Reset in the middle of a frame, at rise 7.
    frame_word = 15'($urandom_range(0, 32767));
    s0 = strobes;
    pulse_inicio();
    wait_rises(7, "mid_reach_rise7");
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", 32'(cs), 32'd1);
    chk("mid_rst_clk_adc", 32'(clk_adc), 32'd0);
    chk("mid_rst_ocupado", 32'(ocupado), 32'd0);
    chk("mid_rst_dato", 32'(dato), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(250);
    chk("mid_rst_no_strobe", strobes, s0);
    w = 15'($urandom_range(0, 32767));
    frame_word = w;
    pulse_inicio();
    wait_strobe(s0 + 1, "post_rst_strobe");
    chk("post_rst_dato", 32'(last_dato), 32'(m_dato(w)));
    chk("post_rst_err", 32'(last_err), 32'(m_err(w)));
    chk("post_rst_latency", strobe_delta, T_FRAME);
    chk("post_rst_rises", rises_at_strobe, TOT);
    wait_idle("post_rst_idle");

    // DIV=1 instance with data tied high.
    s0 = strobes1;
    inicio1 = 1'b1;
    tick(1);
    inicio1 = 1'b0;
    begin
      int n = 0;
      while (strobes1 == s0 && n < 200) begin
        tick(1);
        n++;
      end
    end
    chk("div1_strobe_arrived", strobes1, s0 + 1);
    chk("div1_dato", 32'(ld1), 32'hFFF);
    chk("div1_err", 32'(le1), 32'd1);
    chk("div1_latency", delta1, T_FRAME1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: actual run time exceeded, required finish before 600000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
